ym_slot_cnt_ring: RTL and testbench

- Time-multiplexed counter bank: SLOTS independent DATA_WIDTH-bit counters held in one two-phase (c1/c2) rotating shift ring. One counter is presented and updated per slot tick.
- Parametrised successor to the single-channel two-phase counter cells. Adds channel count, up/down counting, load, wrap or saturate mode, and a built-in slot index with sync.
- Used by envelope, timer and phase units that process one channel per slot.

---
 rtl/ym_lib_pkg.sv | 21 ++
 rtl/ym_slot_cnt_alu.sv | 40 ++++
 rtl/ym_slot_cnt_ring.sv | 82 ++++++++
 tb/tb_ym_slot_cnt_ring.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/ym_lib_pkg.sv
// Shared definitions for the ym slot-multiplexed building blocks:
// operation encodings and a constant-evaluable width helper.
package ym_lib_pkg;

    localparam logic [2:0] OP_HOLD = 3'd0;
    localparam logic [2:0] OP_INC  = 3'd1;
    localparam logic [2:0] OP_DEC  = 3'd2;
    localparam logic [2:0] OP_LOAD = 3'd3;
    localparam logic [2:0] OP_CLR  = 3'd4;

    // Ceiling log2, never below 1 so a 2-entry ring still gets a 1-bit index.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) r = i + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/ym_slot_cnt_alu.sv
// Combinational next-value and carry/borrow logic for one counter slot.
// c_out follows only the count request so clr/load cannot mask an overflow flag.
module ym_slot_cnt_alu
    import ym_lib_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 10,
    parameter bit          SATURATE   = 1'b0
) (
    input  logic [DATA_WIDTH-1:0] head,
    input  logic [DATA_WIDTH-1:0] load_val,
    input  logic [2:0]            op,
    input  logic [2:0]            cnt_op,
    output logic [DATA_WIDTH-1:0] next,
    output logic                  c_out
);

    localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);

    logic all_ones;
    logic is_zero;

    assign all_ones = &head;
    assign is_zero  = ~|head;

    always_comb begin
        c_out = ((cnt_op == OP_INC) && all_ones) || ((cnt_op == OP_DEC) && is_zero);
    end

    always_comb begin
        next = head;
        case (op)
            OP_CLR:  next = '0;
            OP_LOAD: next = load_val;
            OP_INC:  next = (SATURATE && all_ones) ? head : head + ONE;
            OP_DEC:  next = (SATURATE && is_zero) ? head : head - ONE;
            default: next = head;
        endcase
    end

endmodule

// File: rtl/ym_slot_cnt_ring.sv
// Bank of SLOTS counters time-shared through a two-phase rotating ring:
// c1 captures the head's next value into st1, c2 rotates st1 into the tail.
module ym_slot_cnt_ring
    import ym_lib_pkg::*;
#(
    parameter int unsigned SLOTS      = 24,
    parameter int unsigned DATA_WIDTH = 10,
    parameter bit          SATURATE   = 1'b0
) (
    input  logic                      MCLK,
    input  logic                      reset,
    input  logic                      c1,
    input  logic                      c2,
    input  logic                      clr,
    input  logic                      load,
    input  logic [DATA_WIDTH-1:0]     load_val,
    input  logic                      inc,
    input  logic                      dec,
    output logic [DATA_WIDTH-1:0]     val,
    output logic                      c_out,
    output logic [clog2(SLOTS)-1:0]   slot,
    output logic                      sync
);

    localparam int unsigned SW = clog2(SLOTS);

    logic [DATA_WIDTH-1:0] ring_q [SLOTS];
    logic [DATA_WIDTH-1:0] st1_q;
    logic [SW-1:0]         slot_q;
    logic                  sync_q;

    logic [2:0]            cnt_op;
    logic [2:0]            op;
    logic [DATA_WIDTH-1:0] next;
    logic [SW-1:0]         slot_nxt;

    // inc and dec together cancel to a hold.
    always_comb begin
        cnt_op = OP_HOLD;
        if (inc && !dec) cnt_op = OP_INC;
        if (dec && !inc) cnt_op = OP_DEC;
        op = cnt_op;
        if (load) op = OP_LOAD;
        if (clr)  op = OP_CLR;
    end

    ym_slot_cnt_alu #(
        .DATA_WIDTH (DATA_WIDTH),
        .SATURATE   (SATURATE)
    ) u_alu (
        .head     (ring_q[0]),
        .load_val (load_val),
        .op       (op),
        .cnt_op   (cnt_op),
        .next     (next),
        .c_out    (c_out)
    );

    assign slot_nxt = (slot_q == SW'(SLOTS - 1)) ? '0 : slot_q + SW'(1);

    always_ff @(posedge MCLK or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SLOTS; i++) ring_q[i] <= '0;
            st1_q  <= '0;
            slot_q <= '0;
            sync_q <= 1'b1;
        end else begin
            if (c1) st1_q <= next;
            if (c2) begin
                for (int i = 0; i < SLOTS - 1; i++) ring_q[i] <= ring_q[i+1];
                ring_q[SLOTS-1] <= st1_q;
                slot_q          <= slot_nxt;
                sync_q          <= (slot_nxt == '0);
            end
        end
    end

    assign val  = ring_q[0];
    assign slot = slot_q;
    assign sync = sync_q;

endmodule

// File: tb/tb_ym_slot_cnt_ring.sv
// Directed bench: a wrapping and a saturating 4-slot, 4-bit ring driven in lockstep.
module tb_ym_slot_cnt_ring;

    logic       MCLK;
    logic       reset;
    logic       c1, c2, clr, load, inc, dec;
    logic [3:0] load_val;

    logic [3:0] val_w, val_s;
    logic       c_out_w, c_out_s;
    logic [1:0] slot_w, slot_s;
    logic       sync_w, sync_s;

    int         n_checks;
    int         n_fail;
    int         exp_slot;
    logic [3:0] mw [4];
    logic [3:0] ms [4];

    ym_slot_cnt_ring #(.SLOTS(4), .DATA_WIDTH(4), .SATURATE(1'b0)) u_wrap (
        .MCLK(MCLK), .reset(reset), .c1(c1), .c2(c2), .clr(clr), .load(load),
        .load_val(load_val), .inc(inc), .dec(dec), .val(val_w), .c_out(c_out_w),
        .slot(slot_w), .sync(sync_w)
    );

    ym_slot_cnt_ring #(.SLOTS(4), .DATA_WIDTH(4), .SATURATE(1'b1)) u_sat (
        .MCLK(MCLK), .reset(reset), .c1(c1), .c2(c2), .clr(clr), .load(load),
        .load_val(load_val), .inc(inc), .dec(dec), .val(val_s), .c_out(c_out_s),
        .slot(slot_s), .sync(sync_s)
    );

    initial MCLK = 1'b0;
    always #5 MCLK = ~MCLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h slot=%0d t=%0t", tag, got, exp, exp_slot, $time);
        end
    endtask

    // One slot tick from a negedge; nw/ns are the hand-computed next values
    // for the wrap/sat instances, cw/cs the expected carry flags.
    task automatic step(input logic i_clr, input logic i_load, input logic [3:0] lv,
                        input logic i_inc, input logic i_dec,
                        input logic [3:0] nw, input logic [3:0] ns,
                        input logic cw, input logic cs);
        check("slot_w", slot_w, exp_slot);
        check("slot_s", slot_s, exp_slot);
        check("sync_w", sync_w, exp_slot == 0);
        check("val_w", val_w, mw[exp_slot]);
        check("val_s", val_s, ms[exp_slot]);
        clr = i_clr; load = i_load; load_val = lv; inc = i_inc; dec = i_dec; c1 = 1'b1;
        #1;
        check("c_out_w", c_out_w, cw);
        check("c_out_s", c_out_s, cs);
        @(posedge MCLK);
        @(negedge MCLK);
        c1 = 1'b0; clr = 1'b0; load = 1'b0; load_val = '0; inc = 1'b0; dec = 1'b0;
        c2 = 1'b1;
        @(posedge MCLK);
        @(negedge MCLK);
        c2 = 1'b0;
        mw[exp_slot] = nw;
        ms[exp_slot] = ns;
        exp_slot = (exp_slot + 1) % 4;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, mw[exp_slot], ms[exp_slot], 1'b0, 1'b0);
    endtask

    initial begin
        n_checks = 0; n_fail = 0; exp_slot = 0;
        for (int i = 0; i < 4; i++) begin mw[i] = '0; ms[i] = '0; end
        reset = 1'b0; c1 = 1'b0; c2 = 1'b0; clr = 1'b0; load = 1'b0;
        inc = 1'b0; dec = 1'b0; load_val = '0;
        repeat (3) @(negedge MCLK);
        check("rst_val", val_w, 4'd0);
        check("rst_slot", slot_w, 2'd0);
        check("rst_sync", sync_w, 1'b1);
        check("rst_cout", c_out_w, 1'b0);
        reset = 1'b1;
        @(negedge MCLK);

        // Idle rotation: zeros, slot 0..3 twice, sync on slot 0.
        repeat (8) idle();

        // Load 5 into slot 2, then increment it on three visits.
        idle(); idle(); step(1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 4'd5, 4'd5, 1'b0, 1'b0); idle();
        idle(); idle(); step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd6, 4'd6, 1'b0, 1'b0); idle();
        idle(); idle(); step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd7, 4'd7, 1'b0, 1'b0); idle();
        idle(); idle(); step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd8, 4'd8, 1'b0, 1'b0); idle();

        // Overflow at slot 1 and underflow at slot 3, wrap vs saturate.
        idle(); step(1'b0, 1'b1, 4'd15, 1'b0, 1'b0, 4'd15, 4'd15, 1'b0, 1'b0); idle(); idle();
        idle(); step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 4'd15, 1'b1, 1'b1); idle();
        step(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd15, 4'd0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 4'd7, 1'b0, 1'b0, 4'd7, 4'd7, 1'b0, 1'b0); idle(); idle(); idle();

        // Priority: clr beats load beats inc; inc+dec holds.
        step(1'b1, 1'b1, 4'd9, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0); idle(); idle(); idle();
        step(1'b0, 1'b1, 4'd7, 1'b0, 1'b0, 4'd7, 4'd7, 1'b0, 1'b0); idle(); idle(); idle();
        step(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd7, 4'd7, 1'b0, 1'b0); idle(); idle(); idle();
        // Carry flag ignores clr: only the saturated 15 in slot 1 overflows.
        idle(); step(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1); idle(); idle();

        // Fill 1..4, then reset between c1 and c2 of slot 2.
        for (int s = 0; s < 4; s++)
            step(1'b0, 1'b1, 4'(s + 1), 1'b0, 1'b0, 4'(s + 1), 4'(s + 1), 1'b0, 1'b0);
        idle(); idle();
        check("pre_rst_val", val_w, 4'd3);
        inc = 1'b1; c1 = 1'b1;
        @(posedge MCLK);
        @(negedge MCLK);
        c1 = 1'b0; inc = 1'b0;
        reset = 1'b0;
        #1;
        check("mid_rst_val_w", val_w, 4'd0);
        check("mid_rst_val_s", val_s, 4'd0);
        check("mid_rst_slot", slot_w, 2'd0);
        check("mid_rst_sync", sync_w, 1'b1);
        check("mid_rst_cout", c_out_w, 1'b0);
        dec = 1'b1;
        #1;
        check("rst_dec_cout_w", c_out_w, 1'b1);
        check("rst_dec_cout_s", c_out_s, 1'b1);
        dec = 1'b0;
        @(negedge MCLK);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin mw[i] = '0; ms[i] = '0; end
        exp_slot = 0;
        @(negedge MCLK);
        repeat (4) idle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
